// File: rtl/axi_wr_slave_mem.sv
// AXI4 write-channel target backed by a byte-strobed memory. It accepts one AW/W burst at a time
// and returns B after a fixed latency. A combinational debug port reads any memory word.
module axi_wr_slave_mem #(
  parameter int DW        = 64,
  parameter int AW        = 32,
  parameter int TIDW      = 1,
  parameter int USERW     = 1,
  parameter int MEM_DEPTH = 256,
  parameter int B_LATENCY = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [TIDW-1:0]              axi_aw_id_i,
  input  logic [AW-1:0]                axi_aw_addr_i,
  input  logic [7:0]                   axi_aw_len_i,
  input  logic [2:0]                   axi_aw_size_i,
  input  logic [1:0]                   axi_aw_burst_i,
  input  logic                         axi_aw_valid_i,
  output logic                         axi_aw_ready_o,
  input  logic [DW-1:0]                axi_w_data_i,
  input  logic [DW/8-1:0]              axi_w_strb_i,
  input  logic                         axi_w_last_i,
  input  logic                         axi_w_valid_i,
  output logic                         axi_w_ready_o,
  output logic [TIDW-1:0]              axi_b_id_o,
  output logic [1:0]                   axi_b_resp_o,
  output logic [USERW-1:0]             axi_b_user_o,
  output logic                         axi_b_valid_o,
  input  logic                         axi_b_ready_i,
  input  logic [$clog2(MEM_DEPTH)-1:0] dbg_addr_i,
  output logic [DW-1:0]                dbg_data_o,
  output logic [1:0]                   dbg_state_o
);
  localparam int SB   = DW / 8;
  localparam int LSB  = $clog2(SB);
  localparam int IDXW = $clog2(MEM_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]      state_q, state_d;
  logic            aw_ready_q, aw_ready_d;
  logic            w_ready_q, w_ready_d;
  logic            b_valid_q, b_valid_d;
  logic [1:0]      b_resp_q, b_resp_d;
  logic [TIDW-1:0] b_id_q, b_id_d;
  logic [TIDW-1:0] id_q, id_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [7:0]      len_q, len_d;
  logic [2:0]      size_q, size_d;
  logic [1:0]      burst_q, burst_d;
  logic            err_q, err_d;
  logic [8:0]      beat_q, beat_d;
  logic [3:0]      cnt_q, cnt_d;

  logic [DW-1:0]   mem_q [MEM_DEPTH];

  logic            aw_err, w_hs, mem_we;
  logic [AW-1:0]   step, size_mask, wrap_mask, beat_addr;
  logic [IDXW-1:0] word_idx;
  logic            unused_ok;

  // A transfer happens on the rising edge where both valid and ready are high; every ready and
  // valid driven here comes straight from a flop, and B payload is held until BREADY.
  assign w_hs = axi_w_valid_i & w_ready_q;

  assign aw_err = (axi_aw_size_i > 3'(LSB)) || (axi_aw_burst_i == 2'b11) ||
                  ((axi_aw_burst_i == 2'b10) &&
                   !((axi_aw_len_i == 8'd1) || (axi_aw_len_i == 8'd3) ||
                     (axi_aw_len_i == 8'd7) || (axi_aw_len_i == 8'd15)));

  always_comb begin
    step      = AW'(beat_q) << size_q;
    size_mask = (AW'(1) << size_q) - AW'(1);
    wrap_mask = ((AW'(len_q) + AW'(1)) << size_q) - AW'(1);
    case (burst_q)
      2'b00:   beat_addr = addr_q;
      2'b10:   beat_addr = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);
      default: beat_addr = (beat_q == 9'd0) ? addr_q : ((addr_q & ~size_mask) + step);
    endcase
  end

  assign word_idx  = beat_addr[LSB +: IDXW];
  assign mem_we    = w_hs && !err_q && (beat_q <= {1'b0, len_q}) && !rst;
  assign unused_ok = ^beat_addr;

  always_comb begin
    state_d    = state_q;
    aw_ready_d = aw_ready_q;
    w_ready_d  = w_ready_q;
    b_valid_d  = b_valid_q;
    b_resp_d   = b_resp_q;
    b_id_d     = b_id_q;
    id_d       = id_q;
    addr_d     = addr_q;
    len_d      = len_q;
    size_d     = size_q;
    burst_d    = burst_q;
    err_d      = err_q;
    beat_d     = beat_q;
    cnt_d      = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (aw_ready_q && axi_aw_valid_i) begin
          id_d       = axi_aw_id_i;
          addr_d     = axi_aw_addr_i;
          len_d      = axi_aw_len_i;
          size_d     = axi_aw_size_i;
          burst_d    = axi_aw_burst_i;
          err_d      = aw_err;
          beat_d     = 9'd0;
          aw_ready_d = 1'b0;
          w_ready_d  = 1'b1;
          state_d    = S_DATA;
        end else begin
          aw_ready_d = 1'b1;
        end
      end
      S_DATA: begin
        if (w_hs) begin
          // Saturate past the last legal beat so an endless burst never wraps back into range.
          if (beat_q != 9'h100) beat_d = beat_q + 9'd1;
          if (axi_w_last_i) begin
            if (beat_q < {1'b0, len_q}) err_d = 1'b1;
            w_ready_d = 1'b0;
            cnt_d     = 4'd0;
            state_d   = S_WAIT;
          end else if (beat_q == {1'b0, len_q}) begin
            err_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'(B_LATENCY)) begin
          b_valid_d = 1'b1;
          b_resp_d  = err_q ? 2'b10 : 2'b00;
          b_id_d    = id_q;
          state_d   = S_RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        if (axi_b_ready_i) begin
          b_valid_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      b_resp_q   <= 2'b00;
      b_id_q     <= '0;
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      err_q      <= 1'b0;
      beat_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      aw_ready_q <= aw_ready_d;
      w_ready_q  <= w_ready_d;
      b_valid_q  <= b_valid_d;
      b_resp_q   <= b_resp_d;
      b_id_q     <= b_id_d;
      id_q       <= id_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      size_q     <= size_d;
      burst_q    <= burst_d;
      err_q      <= err_d;
      beat_q     <= beat_d;
      cnt_q      <= cnt_d;
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < SB; i++) begin
        if (axi_w_strb_i[i]) mem_q[word_idx][i*8 +: 8] <= axi_w_data_i[i*8 +: 8];
      end
    end
  end

  assign axi_aw_ready_o = aw_ready_q;
  assign axi_w_ready_o  = w_ready_q;
  assign axi_b_valid_o  = b_valid_q;
  assign axi_b_resp_o   = b_resp_q;
  assign axi_b_id_o     = b_id_q;
  assign axi_b_user_o   = '0;
  assign dbg_data_o     = mem_q[dbg_addr_i];
  assign dbg_state_o    = state_q;
endmodule
